// File: rtl/fifo_tx_serializer.sv
// -----------------------------------------------------------------------------
// fifo_tx_serializer
//
// Read-side consumer of a synchronous FIFO. Pops one word at a time and
// serialises it onto a UART-style line: start bit (0), DATA_WIDTH data bits
// MSB-first, optional even-parity bit, stop bit (1). Every line bit is held
// for CLKS_PER_BIT clock cycles. All outputs are registered.
//
// Optional feature: define FIFO_TX_PARITY_EN to insert an even-parity bit
// (XOR of all data bits) between the last data bit and the stop bit.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   tx_en         in   permission to start new frames
//   fifo_empty    in   FIFO empty flag
//   fifo_data_out in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en    out  FIFO pop strobe (one cycle per word)
//   tx_out        out  serial line, idles high
//   busy          out  high whenever the FSM is not idle
//   tx_done       out  one-cycle pulse on the last cycle of the stop bit
//   word_cnt      out  completed frames, wraps modulo 2^CNT_WIDTH
// -----------------------------------------------------------------------------
module fifo_tx_serializer #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  // Counter widths are kept at least one bit so CLKS_PER_BIT=1 still elaborates.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    STOP
`ifdef FIFO_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t                state_reg, state_next;
  logic [BAUD_W-1:0]     baud_reg, baud_next;
  logic [BIT_W-1:0]      bit_reg, bit_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  tx_out_reg, tx_out_next;
  logic                  rd_en_reg, rd_en_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic [CNT_WIDTH-1:0]  word_cnt_reg, word_cnt_next;
  logic                  baud_last;
`ifdef FIFO_TX_PARITY_EN
  logic                  parity_reg, parity_next;
`endif

  assign baud_last = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    tx_out_next = tx_out_reg;
    rd_en_next  = 1'b0;
`ifdef FIFO_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        tx_out_next = 1'b1;
        // Only pop when the FIFO reports data, so underflow is impossible.
        if (tx_en && !fifo_empty) begin
          state_next = POP;
          rd_en_next = 1'b1;
        end
      end
      POP: state_next = LOAD;
      LOAD: begin
        // FIFO read data is valid exactly now; capture it and start the frame.
        shift_next  = fifo_data_out;
`ifdef FIFO_TX_PARITY_EN
        parity_next = ^fifo_data_out;
`endif
        baud_next   = '0;
        tx_out_next = 1'b0;
        state_next  = START;
      end
      START: begin
        if (baud_last) begin
          baud_next   = '0;
          bit_next    = '0;
          tx_out_next = shift_reg[DATA_WIDTH-1];
          state_next  = DATA;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_reg == BIT_LAST) begin
`ifdef FIFO_TX_PARITY_EN
            tx_out_next = parity_reg;
            state_next  = PARITY;
`else
            tx_out_next = 1'b1;
            state_next  = STOP;
`endif
          end else begin
            bit_next    = bit_reg + BIT_W'(1);
            shift_next  = shift_reg << 1;
            // Next bit on the line is the one that becomes MSB after the shift.
            tx_out_next = shift_reg[DATA_WIDTH-2];
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
`ifdef FIFO_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_next   = '0;
          tx_out_next = 1'b1;
          state_next  = STOP;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_next   = '0;
          tx_out_next = 1'b1;
          state_next  = IDLE;
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      default: begin
        tx_out_next = 1'b1;
        state_next  = IDLE;
      end
    endcase
    // Registered pulse: high during the cycle in which STOP holds its last baud count.
    done_next     = (state_next == STOP) && (baud_next == BAUD_LAST);
    word_cnt_next = word_cnt_reg + CNT_WIDTH'(done_next);
    busy_next     = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_reg     <= '0;
      bit_reg      <= '0;
      shift_reg    <= '0;
      tx_out_reg   <= 1'b1;
      rd_en_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      word_cnt_reg <= '0;
`ifdef FIFO_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      baud_reg     <= baud_next;
      bit_reg      <= bit_next;
      shift_reg    <= shift_next;
      tx_out_reg   <= tx_out_next;
      rd_en_reg    <= rd_en_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      word_cnt_reg <= word_cnt_next;
`ifdef FIFO_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  assign fifo_rd_en = rd_en_reg;
  assign tx_out     = tx_out_reg;
  assign busy       = busy_reg;
  assign tx_done    = done_reg;
  assign word_cnt   = word_cnt_reg;

endmodule
